v2f_programmable_ram_mp: RTL
============================

Name: v2f_programmable_ram_mp

Overview:
Multi-read-port, single-write-port synchronous RAM with per-byte write select, a configurable read pipeline and a built-in clear sequencer.
- Generalised successor to the single-port programmable RAM, in width, depth and read-port count.
- Adds read-valid strobes, address range checking, a selectable read-during-write mode and a hardware memory-clear state machine.
- Sits behind the v2f memory mapper as the standard storage primitive for multi-reader designs.

Parameters:
WIDTH, 32, data word width in bits; must be a multiple of BYTE_WIDTH
BYTE_WIDTH, 8, bits per byte lane
SIZE, 16, number of words
ABITS, 4, address width
OFFSET, 0, address of word 0; physical index = ADDR - OFFSET
RD_PORTS, 2, number of independent read ports (1..8)
RD_LATENCY, 1, cycles from RD_EN sample to RD_DATA/RD_VALID; legal values 1 or 2
TRANSPARENT, 0, 1 = read-during-write returns new data; 0 = returns old data
CLEAR_ON_RESET, 1, 1 = clear sequence starts automatically when ARST deasserts

Ports:
CLK  input  1  clock, rising edge
ARST  input  1  asynchronous reset, active-high
CLEAR  input  1  one-cycle request to zero the whole memory
BUSY  output  1  high while the clear sequence runs
WR_EN  input  1  write strobe
WR_ADDR  input  ABITS  write address
WR_DATA  input  WIDTH  write data
BYTE_SELECT  input  WIDTH/BYTE_WIDTH  per-lane write enable
RD_EN  input  RD_PORTS  per-port read strobe
RD_ADDR  input  RD_PORTS*ABITS  packed read addresses, port i at [i*ABITS +: ABITS]
RD_DATA  output  RD_PORTS*WIDTH  packed read data, port i at [i*WIDTH +: WIDTH]
RD_VALID  output  RD_PORTS  per-port data-valid strobe
ADDR_ERR  output  1  one-cycle pulse on an out-of-range access

Behaviour:
- One clock (CLK); reset is asynchronous and active-high (ARST). All state updates on the rising CLK edge.
- While ARST is high:
  - RD_DATA=0, RD_VALID=0, ADDR_ERR=0, clear pointer=0, read pipeline flushed.
  - BUSY=0 while ARST is asserted.
  - State is CLEARING if CLEAR_ON_RESET=1, otherwise IDLE; BUSY goes to 1 on the first clock after release when CLEARING.
  - Memory array is not reset directly.
- FSM states:
  - IDLE -> CLEARING on CLEAR=1.
  - CLEARING writes 0 to word[ptr] each cycle and increments ptr.
  - When ptr==SIZE-1 is written: ptr returns to 0 and state -> IDLE. Clear takes exactly SIZE cycles.
  - CLEAR asserted while CLEARING is ignored (no restart).
  - ARST mid-clear aborts the sequence; it restarts from 0 per CLEAR_ON_RESET.
- BUSY=1 exactly while in CLEARING. While BUSY:
  - WR_EN is ignored.
  - RD_EN is ignored: no RD_VALID, RD_DATA holds its value.
- Write (IDLE, WR_EN=1, index=WR_ADDR-OFFSET in [0,SIZE-1]): for each lane b with BYTE_SELECT[b]=1, word[index][b*BYTE_WIDTH +: BYTE_WIDTH] <= WR_DATA lane b. Unselected lanes are unchanged. BYTE_SELECT=0 is a legal no-op.
- Read, port i (IDLE, RD_EN[i]=1): address sampled at edge N; RD_DATA[i] and RD_VALID[i]=1 appear after edge N+RD_LATENCY-1 (i.e. usable at edge N+RD_LATENCY).
  - RD_VALID[i] is a single-cycle pulse per accepted read.
  - RD_DATA[i] holds its last value when no read completes.
  - Back-to-back reads are fully pipelined: one per cycle per port.
- All read ports are independent. Any number of ports may read the same address in the same cycle.
- Read-during-write to the same index in the same cycle:
  - TRANSPARENT=1: selected lanes return WR_DATA, unselected lanes return old data.
  - TRANSPARENT=0: all lanes return old data.
- Out of range (index <0 or >=SIZE, computed with ABITS+1-bit signed arithmetic):
  - Write is dropped.
  - Read completes with RD_DATA=0 and RD_VALID=1.
  - ADDR_ERR pulses one cycle after the offending edge. Multiple offenders in one cycle produce one pulse.
- A read and a write at different addresses in the same cycle do not interact.

Test Plan:
- CLEAR_ON_RESET=1, SIZE=16: release ARST -> BUSY=1 for exactly 16 cycles; then read of every address returns 0x00000000 with RD_VALID.
- Write 0xDEADBEEF to addr 3 with BYTE_SELECT=4'b1111, then write 0x11223344 with BYTE_SELECT=4'b0101 -> read addr 3 = 0xDE22BE44.
- TRANSPARENT=0 and TRANSPARENT=1 builds: addr 5 holds 0xAAAAAAAA; same cycle write 0x55555555 (BYTE_SELECT=4'b0011) and read 5 on port 0 -> 0xAAAAAAAA and 0xAAAA5555 respectively.
- RD_LATENCY=2, port 0 reads addrs 0,1,2 back-to-back while port 1 reads 2,1,0 -> three consecutive RD_VALID pulses per port, starting 2 cycles after the first RD_EN, with correct data order.
- OFFSET=4, SIZE=16: write to addr 2 and read addr 20 -> write dropped, RD_DATA=0 with RD_VALID=1, single ADDR_ERR pulse.
- Pulse CLEAR in IDLE, assert ARST at cycle 7 of the clear, release -> clear restarts from ptr 0 and BUSY lasts a full 16 cycles; WR_EN during BUSY has no effect.

Source files
------------

// File: rtl/v2f_programmable_ram_mp_if.sv
`default_nettype none
// ============================================================================
// Module      : v2f_programmable_ram_mp_if
// Description : Bus bundle for the multi-read-port programmable RAM.
//               master : the client driving writes, reads and clear requests
//               slave  : the RAM itself
//   CLEAR/BUSY            clear request and clear-in-progress flag
//   WR_EN/WR_ADDR/WR_DATA write port, BYTE_SELECT per-lane enable
//   RD_EN/RD_ADDR         packed per-port read requests
//   RD_DATA/RD_VALID      packed per-port read results
//   ADDR_ERR              out-of-range access pulse
// Revision    : 1.0 - initial release
// ============================================================================
interface v2f_programmable_ram_mp_if #(
    parameter int WIDTH      = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int ABITS      = 4,
    parameter int RD_PORTS   = 2
);
    localparam int c_lanes = WIDTH / BYTE_WIDTH;

    logic                         CLEAR;
    logic                         BUSY;
    logic                         WR_EN;
    logic [ABITS-1:0]             WR_ADDR;
    logic [WIDTH-1:0]             WR_DATA;
    logic [c_lanes-1:0]           BYTE_SELECT;
    logic [RD_PORTS-1:0]          RD_EN;
    logic [RD_PORTS*ABITS-1:0]    RD_ADDR;
    logic [RD_PORTS*WIDTH-1:0]    RD_DATA;
    logic [RD_PORTS-1:0]          RD_VALID;
    logic                         ADDR_ERR;

    modport master (
        output CLEAR, WR_EN, WR_ADDR, WR_DATA, BYTE_SELECT, RD_EN, RD_ADDR,
        input  BUSY, RD_DATA, RD_VALID, ADDR_ERR
    );

    modport slave (
        input  CLEAR, WR_EN, WR_ADDR, WR_DATA, BYTE_SELECT, RD_EN, RD_ADDR,
        output BUSY, RD_DATA, RD_VALID, ADDR_ERR
    );
endinterface
`default_nettype wire

// File: rtl/v2f_programmable_ram_mp.sv
`default_nettype none
// ============================================================================
// Module      : v2f_programmable_ram_mp
// Description : Single-write, multi-read synchronous RAM with per-byte write
//               enables, 1- or 2-cycle read pipeline, selectable
//               read-during-write behaviour, address range checking and a
//               hardware clear sequencer.
//   CLK  : rising-edge clock
//   ARST : asynchronous active-high reset (memory array itself not reset)
//   bus  : slave side of v2f_programmable_ram_mp_if (write port, packed
//          read ports, CLEAR/BUSY, ADDR_ERR)
// Revision    : 1.0 - initial release
// ============================================================================
module v2f_programmable_ram_mp #(
    parameter int WIDTH          = 32,
    parameter int BYTE_WIDTH     = 8,
    parameter int SIZE           = 16,
    parameter int ABITS          = 4,
    parameter int OFFSET         = 0,
    parameter int RD_PORTS       = 2,
    parameter int RD_LATENCY     = 1,
    parameter int TRANSPARENT    = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input wire                       CLK,
    input wire                       ARST,
    v2f_programmable_ram_mp_if.slave bus
);
    localparam int             c_lanes  = WIDTH / BYTE_WIDTH;
    localparam int             c_pw     = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [ABITS:0] c_offset = (ABITS+1)'(OFFSET);
    localparam logic [ABITS:0] c_size   = (ABITS+1)'(SIZE);

    // ST_PEND is the one-cycle holding state out of reset: BUSY stays low
    // while ARST is high and rises on the first clock after release.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PEND  = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    localparam state_t c_rst_state = (CLEAR_ON_RESET != 0) ? ST_PEND : ST_IDLE;

    // Physical index = address - OFFSET in ABITS+1-bit two's complement;
    // the top bit set means the address lies below OFFSET.
    function automatic logic [ABITS:0] f_index(input logic [ABITS-1:0] addr);
        return {1'b0, addr} - c_offset;
    endfunction

    function automatic logic f_in_range(input logic [ABITS:0] idx);
        return !idx[ABITS] && (idx < c_size);
    endfunction

    logic [WIDTH-1:0] r_mem [SIZE];

    state_t           r_state;
    state_t           w_state_nxt;
    logic [c_pw-1:0]  r_ptr;
    logic [c_pw-1:0]  w_ptr_nxt;
    logic             w_idle;
    logic             w_clr_last;

    logic [ABITS:0]   w_wr_idx;
    logic             w_wr_ok;
    logic             w_wr_fire;
    logic [WIDTH-1:0] w_wr_mask;
    logic [RD_PORTS-1:0] w_rd_ok;
    logic             w_err;
    logic             r_addr_err;

    // ------------------------------------------------------------------
    // Clear sequencer
    // ------------------------------------------------------------------
    assign w_idle     = (r_state == ST_IDLE);
    assign w_clr_last = (r_ptr == c_pw'(SIZE - 1));

    always_ff @(posedge CLK or posedge ARST) begin
        if (ARST) begin
            r_state <= c_rst_state;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            ST_IDLE: begin
                if (bus.CLEAR) begin
                    w_state_nxt = ST_CLEAR;
                end
            end
            ST_PEND: begin
                w_state_nxt = ST_CLEAR;
            end
            ST_CLEAR: begin
                // CLEAR is not looked at here, so a repeat request cannot
                // restart a sequence already in progress.
                if (w_clr_last) begin
                    w_state_nxt = ST_IDLE;
                    w_ptr_nxt   = '0;
                end else begin
                    w_ptr_nxt   = r_ptr + c_pw'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_ptr_nxt   = '0;
            end
        endcase
    end

    assign bus.BUSY = (r_state == ST_CLEAR);

    // ------------------------------------------------------------------
    // Write port
    // ------------------------------------------------------------------
    assign w_wr_idx  = f_index(bus.WR_ADDR);
    assign w_wr_ok   = f_in_range(w_wr_idx);
    assign w_wr_fire = w_idle && bus.WR_EN && w_wr_ok;

    for (genvar b = 0; b < c_lanes; b++) begin : g_lane_mask
        assign w_wr_mask[b*BYTE_WIDTH +: BYTE_WIDTH] = {BYTE_WIDTH{bus.BYTE_SELECT[b]}};
    end

    always_ff @(posedge CLK) begin
        if (r_state == ST_CLEAR) begin
            r_mem[r_ptr] <= '0;
        end else if (w_wr_fire) begin
            r_mem[w_wr_idx[c_pw-1:0]] <= (r_mem[w_wr_idx[c_pw-1:0]] & ~w_wr_mask)
                                       | (bus.WR_DATA & w_wr_mask);
        end
    end

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    for (genvar i = 0; i < RD_PORTS; i++) begin : g_rd_port
        logic [ABITS:0]   w_idx;
        logic             w_ok;
        logic             w_hit;
        logic             w_accept;
        logic [WIDTH-1:0] w_old;
        logic [WIDTH-1:0] w_val;
        logic             r_s1_valid;
        logic [WIDTH-1:0] r_s1_data;

        assign w_idx      = f_index(bus.RD_ADDR[i*ABITS +: ABITS]);
        assign w_ok       = f_in_range(w_idx);
        assign w_rd_ok[i] = w_ok;
        assign w_accept   = w_idle && bus.RD_EN[i];
        assign w_old      = r_mem[w_idx[c_pw-1:0]];
        // Same-cycle collision with the write port: the array still holds
        // the old word, so the new lanes are forwarded from WR_DATA.
        assign w_hit      = (TRANSPARENT != 0) && w_wr_fire && (w_idx == w_wr_idx);
        assign w_val      = !w_ok  ? '0
                          : w_hit  ? ((w_old & ~w_wr_mask) | (bus.WR_DATA & w_wr_mask))
                          :          w_old;

        // Data registers load only on a completing read so RD_DATA holds.
        always_ff @(posedge CLK or posedge ARST) begin
            if (ARST) begin
                r_s1_valid <= 1'b0;
                r_s1_data  <= '0;
            end else begin
                r_s1_valid <= w_accept;
                if (w_accept) begin
                    r_s1_data <= w_val;
                end
            end
        end

        if (RD_LATENCY == 2) begin : g_lat2
            logic             r_s2_valid;
            logic [WIDTH-1:0] r_s2_data;

            always_ff @(posedge CLK or posedge ARST) begin
                if (ARST) begin
                    r_s2_valid <= 1'b0;
                    r_s2_data  <= '0;
                end else begin
                    r_s2_valid <= r_s1_valid;
                    if (r_s1_valid) begin
                        r_s2_data <= r_s1_data;
                    end
                end
            end

            assign bus.RD_VALID[i]               = r_s2_valid;
            assign bus.RD_DATA[i*WIDTH +: WIDTH] = r_s2_data;
        end else begin : g_lat1
            assign bus.RD_VALID[i]               = r_s1_valid;
            assign bus.RD_DATA[i*WIDTH +: WIDTH] = r_s1_data;
        end
    end

    // ------------------------------------------------------------------
    // Address error: one pulse per cycle however many ports offend, always
    // one cycle after the edge regardless of read latency.
    // ------------------------------------------------------------------
    assign w_err = w_idle && ((bus.WR_EN && !w_wr_ok) || |(bus.RD_EN & ~w_rd_ok));

    always_ff @(posedge CLK or posedge ARST) begin
        if (ARST) begin
            r_addr_err <= 1'b0;
        end else begin
            r_addr_err <= w_err;
        end
    end

    assign bus.ADDR_ERR = r_addr_err;

endmodule
`default_nettype wire
